program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum instruction words accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: idle-cycle limit between bytes once loading has started.
REQ-003 SHALL have port clock, input, 1 bit: single clock for all state.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_byte holds a valid byte.
REQ-006 SHALL have port rx_byte, input, 8 bits: incoming program byte.
REQ-007 SHALL have port rx_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-009 SHALL have port imem_addr, output, 32 bits: byte address of the word being written.
REQ-010 SHALL have port imem_wdata, output, 32 bits: instruction word being written.
REQ-011 SHALL have port core_hold, output, 1 bit: high keeps the MIPS core in reset.
REQ-012 SHALL have port err_code, output, 2 bits: 0 none, 1 checksum, 2 oversize, 3 timeout.

Function
REQ-013 SHALL accept a byte on each rising edge where rx_valid and rx_ready are both high; no other edge consumes a byte.
REQ-014 SHALL implement the states CNT_HI, CNT_LO, DATA, WRITE, CHECK, RUN and ERROR.
REQ-015 SHALL, in CNT_HI then CNT_LO, capture the word count N as 16 bits, high byte first.
REQ-016 SHALL go from CNT_LO to ERROR with err_code=2 when N>MAX_WORDS, to CHECK when N=0, and otherwise to DATA.
REQ-017 SHALL, in DATA, assemble the word big-endian (first byte to bits 31:24) and enter WRITE on the 4th byte.
REQ-018 SHALL, in WRITE, hold rx_ready low and imem_we high for exactly one cycle, with imem_addr=4*k and imem_wdata equal to the assembled k-th word (k from 0).
REQ-019 SHALL leave WRITE for DATA when words remain, and otherwise for CHECK.
REQ-020 SHALL, in CHECK, compare the received byte with the XOR of all data bytes; a match enters RUN, a mismatch enters ERROR with err_code=1.
REQ-021 SHALL drive rx_ready high in CNT_HI, CNT_LO, DATA and CHECK, and low in WRITE, RUN and ERROR.
REQ-022 SHALL drive core_hold high in every state except RUN; core_hold falls on the edge that enters RUN.
REQ-023 SHALL count consecutive cycles without an accepted byte while in CNT_LO, DATA or CHECK; reaching TIMEOUT_CYCLES enters ERROR with err_code=3.
REQ-024 SHALL clear the timeout counter on every accepted byte; CNT_HI never times out.
REQ-025 SHALL treat RUN and ERROR as absorbing; only reset leaves them.
REQ-026 SHALL hold imem_we at 0 outside WRITE; imem_addr and imem_wdata are don't-care when imem_we=0.
REQ-027 SHALL ignore rx_valid whenever rx_ready is low; such bytes are neither consumed nor counted.

Reset
REQ-028 SHALL, on reset low at any time including mid-load, immediately force state CNT_HI, core_hold=1, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, err_code=0, and clear the checksum, word counter, byte counter and timeout counter.
REQ-029 SHALL leave words already written to instruction memory untouched by reset; the next load overwrites them from address 0.

Configuration
REQ-030 SHALL include the CHECK state and checksum logic when macro PROGRAM_LOADER_CHECKSUM_EN is defined.
REQ-031 SHALL, without PROGRAM_LOADER_CHECKSUM_EN, omit CHECK, enter RUN directly from WRITE after the last word (or from CNT_LO when N=0), and never report err_code=1.

Verification
REQ-032 SHALL verify: bytes 00 01 20 08 00 05 checksum 2D -> one imem_we pulse, addr 0x0, data 0x20080005, then core_hold=0, err_code=0.
REQ-033 SHALL verify: N=2 with words 0x8C090000 and 0xAC090004, bad checksum 00 -> two writes at 0x0 and 0x4, then ERROR, err_code=1, core_hold stays 1, rx_ready=0.
REQ-034 SHALL verify: count bytes 01 01 (N=257) -> ERROR with err_code=2 and no imem_we pulse.
REQ-035 SHALL verify: with TIMEOUT_CYCLES=16, stall after the 2nd data byte -> err_code=3 exactly 16 cycles after the last accepted byte.
REQ-036 SHALL verify: reset pulsed low mid-DATA, then a fresh load of N=1 -> write at addr 0x0 and normal RUN.
REQ-037 SHALL verify: rx_valid held high continuously -> no byte is consumed during WRITE cycles, and the word order is preserved.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - serial boot loader that streams a counted program into instruction memory
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (adds CHECK state and trailing XOR checksum byte)
module program_loader #(
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic [1:0]  err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Value of the idle counter on the cycle whose missing byte reaches the limit.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd4,
`endif
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     word_idx_q, word_idx_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     word_q, word_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      err_q, err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif
  logic            accept;
  logic            timed_state;
  logic [15:0]     n_cnt;
  state_e          done_state;

  // Byte-accepting states; everything else stalls the sender.
  always_comb begin
    rx_ready    = 1'b0;
    timed_state = 1'b0;
    case (state_q)
      S_CNT_HI: rx_ready = 1'b1;
      S_CNT_LO: begin rx_ready = 1'b1; timed_state = 1'b1; end
      S_DATA:   begin rx_ready = 1'b1; timed_state = 1'b1; end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:  begin rx_ready = 1'b1; timed_state = 1'b1; end
`endif
      default:  begin rx_ready = 1'b0; timed_state = 1'b0; end
    endcase
  end

  assign accept     = rx_valid & rx_ready;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign done_state = S_CHECK;
`else
  assign done_state = S_RUN;
`endif

  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = {14'd0, word_idx_q, 2'b00};
  assign imem_wdata = word_q;
  assign core_hold  = (state_q != S_RUN);
  assign err_code   = err_q;

  // Next-state logic: count capture, word assembly, write sequencing and idle timeout.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = err_q;
    tmo_d      = '0;
    n_cnt      = {count_q[15:8], rx_byte};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_CNT_HI: begin
        if (accept) begin
          count_d = {rx_byte, 8'h00};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          count_d = n_cnt;
          if ({16'h0000, n_cnt} > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 2'd2;
          end else if (n_cnt == 16'd0) begin
            state_d = done_state;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d     = {word_q[23:0], rx_byte};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ rx_byte;
`endif
          if (byte_cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_d == count_q) ? done_state : S_DATA;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) begin
          if (rx_byte == csum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERROR;
            err_d   = 2'd1;
          end
        end
      end
`endif
      default: state_d = state_q;
    endcase
    // Idle cycles only count once the count header has started arriving.
    if (timed_state && !accept) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_LAST) begin
        state_d = S_ERROR;
        err_d   = 2'd3;
      end
    end
  end

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CNT_HI;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;
  int we_ready_clash = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  seq[$];

  program_loader #(.MAX_WORDS(256), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .err_code(err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every memory write seen mid-cycle.
  always @(negedge clock) begin
    if (reset && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      if (rx_ready) we_ready_clash++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and hold it until an edge with rx_ready high takes it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = b;
    while (!rx_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) begin
      check_eq("rx_ready_wait", 32'(rx_ready), 32'd1);
    end else begin
      @(posedge clock);
    end
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic idle(input int cycles);
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rx_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    we_ready_clash = 0;
  endtask

  initial begin
    reset = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    repeat (3) @(negedge clock);
    check_eq("rst_core_hold", 32'(core_hold), 32'd1);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("rst_imem_we", 32'(imem_we), 32'd0);
    check_eq("rst_imem_addr", imem_addr, 32'd0);
    check_eq("rst_imem_wdata", imem_wdata, 32'd0);
    check_eq("rst_err", 32'(err_code), 32'd0);
    reset = 1'b1;

    // CNT_HI waits indefinitely for the first byte.
    idle(40);
    check_eq("cnthi_no_tmo_err", 32'(err_code), 32'd0);
    check_eq("cnthi_no_tmo_ready", 32'(rx_ready), 32'd1);

    // Single word load.
    seq = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
    send_seq();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h2D);
`endif
    idle(4);
    check_eq("t1_nwr", 32'(wr_addr_q.size()), 32'd1);
    check_eq("t1_addr", wr_addr_q[0], 32'h0);
    check_eq("t1_data", wr_data_q[0], 32'h20080005);
    check_eq("t1_hold", 32'(core_hold), 32'd0);
    check_eq("t1_err", 32'(err_code), 32'd0);
    check_eq("t1_ready", 32'(rx_ready), 32'd0);

    // Two words, wrong checksum.
    do_reset();
    seq = '{8'h00, 8'h02, 8'h8C, 8'h09, 8'h00, 8'h00, 8'hAC, 8'h09, 8'h00, 8'h04};
    send_seq();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(4);
    check_eq("t2_nwr", 32'(wr_addr_q.size()), 32'd2);
    check_eq("t2_addr0", wr_addr_q[0], 32'h0);
    check_eq("t2_data0", wr_data_q[0], 32'h8C090000);
    check_eq("t2_addr1", wr_addr_q[1], 32'h4);
    check_eq("t2_data1", wr_data_q[1], 32'hAC090004);
    check_eq("t2_ready", 32'(rx_ready), 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    check_eq("t2_err", 32'(err_code), 32'd1);
    check_eq("t2_hold", 32'(core_hold), 32'd1);
`else
    check_eq("t2_err", 32'(err_code), 32'd0);
    check_eq("t2_hold", 32'(core_hold), 32'd0);
`endif

    // Oversize count.
    do_reset();
    seq = '{8'h01, 8'h01};
    send_seq();
    idle(4);
    check_eq("t3_err", 32'(err_code), 32'd2);
    check_eq("t3_nwr", 32'(wr_addr_q.size()), 32'd0);
    check_eq("t3_hold", 32'(core_hold), 32'd1);
    check_eq("t3_ready", 32'(rx_ready), 32'd0);

    // Exactly MAX_WORDS is accepted.
    do_reset();
    seq = '{8'h01, 8'h00};
    send_seq();
    idle(2);
    check_eq("t3b_err", 32'(err_code), 32'd0);
    check_eq("t3b_ready", 32'(rx_ready), 32'd1);

    // Timeout 16 cycles after the 2nd data byte.
    do_reset();
    seq = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_seq();
    @(negedge clock);
    rx_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      if (k == 15) check_eq("t4_err_at15", 32'(err_code), 32'd0);
      if (k == 16) check_eq("t4_err_at16", 32'(err_code), 32'd3);
    end
    check_eq("t4_ready", 32'(rx_ready), 32'd0);
    check_eq("t4_hold", 32'(core_hold), 32'd1);

    // Reset mid-DATA, then a fresh single-word load.
    do_reset();
    seq = '{8'h00, 8'h02, 8'h11, 8'h22};
    send_seq();
    @(negedge clock);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("t5_rst_ready", 32'(rx_ready), 32'd1);
    check_eq("t5_rst_wdata", imem_wdata, 32'd0);
    check_eq("t5_rst_hold", 32'(core_hold), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    wr_addr_q.delete();
    wr_data_q.delete();
    seq = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_seq();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    idle(4);
    check_eq("t5_nwr", 32'(wr_addr_q.size()), 32'd1);
    check_eq("t5_addr", wr_addr_q[0], 32'h0);
    check_eq("t5_data", wr_data_q[0], 32'hDEADBEEF);
    check_eq("t5_hold", 32'(core_hold), 32'd0);
    check_eq("t5_err", 32'(err_code), 32'd0);

    // rx_valid never drops: WRITE cycles must not swallow bytes.
    do_reset();
    seq = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
            8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_seq();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h0C);
`endif
    repeat (4) @(negedge clock);
    check_eq("t6_nwr", 32'(wr_addr_q.size()), 32'd3);
    check_eq("t6_addr0", wr_addr_q[0], 32'h0);
    check_eq("t6_data0", wr_data_q[0], 32'h01020304);
    check_eq("t6_addr1", wr_addr_q[1], 32'h4);
    check_eq("t6_data1", wr_data_q[1], 32'h05060708);
    check_eq("t6_addr2", wr_addr_q[2], 32'h8);
    check_eq("t6_data2", wr_data_q[2], 32'h090A0B0C);
    check_eq("t6_clash", 32'(we_ready_clash), 32'd0);
    check_eq("t6_hold", 32'(core_hold), 32'd0);
    check_eq("t6_err", 32'(err_code), 32'd0);
    rx_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
